// File: rtl/regfile_wr_arbiter.sv
// Arbitrates the register-file write port between ALU (A) and load (L) writeback.
// Each port has a one-entry buffer. Same-register writes drain in age order.
module regfile_wr_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [REG_AW-1:0]        a_reg,
  input  logic [DATA_W-1:0]        a_data,
  input  logic                     l_valid,
  output logic                     l_ready,
  input  logic [REG_AW-1:0]        l_reg,
  input  logic [DATA_W-1:0]        l_data,
  output logic                     WriteReg,
  output logic [REG_AW-1:0]        DstReg,
  output logic [DATA_W-1:0]        DstData,
  output logic [(2**REG_AW)-1:0]   pend_mask
);

  logic              a_v_q, a_v_d, l_v_q, l_v_d;
  logic [REG_AW-1:0] a_reg_q, a_reg_d, l_reg_q, l_reg_d;
  logic [DATA_W-1:0] a_data_q, a_data_d, l_data_q, l_data_d;
  logic              older_q, older_d;   // 1: L entry older than A entry
  logic              last_q, last_d;     // 1: L granted last
  logic              grant_a, grant_l;
  logic              a_cap, l_cap;

  always_comb begin
    grant_a = 1'b0;
    grant_l = 1'b0;
    if (!flush) begin
      if (a_v_q && l_v_q) begin
        if (a_reg_q == l_reg_q) begin
          grant_l = older_q;
          grant_a = ~older_q;
        end else if (RR_EN) begin
          grant_l = ~last_q;
          grant_a = last_q;
        end else begin
          grant_l = 1'b1;
        end
      end else begin
        grant_a = a_v_q;
        grant_l = l_v_q;
      end
    end
  end

  assign a_ready = rst_n & ~flush & (~a_v_q | grant_a);
  assign l_ready = rst_n & ~flush & (~l_v_q | grant_l);
  assign a_cap   = a_valid & a_ready & (a_reg != '0);
  assign l_cap   = l_valid & l_ready & (l_reg != '0);

  // A fresh capture is always younger than whatever survives in the other
  // buffer; a simultaneous capture on both ports makes L the older one.
  always_comb begin
    a_v_d    = a_v_q;
    a_reg_d  = a_reg_q;
    a_data_d = a_data_q;
    l_v_d    = l_v_q;
    l_reg_d  = l_reg_q;
    l_data_d = l_data_q;
    older_d  = older_q;
    last_d   = last_q;
    if (flush) begin
      a_v_d = 1'b0;
      l_v_d = 1'b0;
    end else begin
      if (grant_a) begin
        a_v_d  = 1'b0;
        last_d = 1'b0;
      end
      if (grant_l) begin
        l_v_d  = 1'b0;
        last_d = 1'b1;
      end
      if (a_cap) begin
        a_v_d    = 1'b1;
        a_reg_d  = a_reg;
        a_data_d = a_data;
        older_d  = 1'b1;
      end
      if (l_cap) begin
        l_v_d    = 1'b1;
        l_reg_d  = l_reg;
        l_data_d = l_data;
        if (!a_cap) older_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v_q    <= 1'b0;
      a_reg_q  <= '0;
      a_data_q <= '0;
      l_v_q    <= 1'b0;
      l_reg_q  <= '0;
      l_data_q <= '0;
      older_q  <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      a_v_q    <= a_v_d;
      a_reg_q  <= a_reg_d;
      a_data_q <= a_data_d;
      l_v_q    <= l_v_d;
      l_reg_q  <= l_reg_d;
      l_data_q <= l_data_d;
      older_q  <= older_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    WriteReg = grant_a | grant_l;
    DstReg   = '0;
    DstData  = '0;
    if (grant_a) begin
      DstReg  = a_reg_q;
      DstData = a_data_q;
    end else if (grant_l) begin
      DstReg  = l_reg_q;
      DstData = l_data_q;
    end
  end

  always_comb begin
    pend_mask = '0;
    if (a_v_q) pend_mask[a_reg_q] = 1'b1;
    if (l_v_q) pend_mask[l_reg_q] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against
// an age-stamped entry model of the two writeback buffers.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        a_valid, a_ready, l_valid, l_ready;
  logic [3:0]  a_reg, l_reg, DstReg;
  logic [15:0] a_data, l_data, DstData, pend_mask;
  logic        WriteReg;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_W(16), .REG_AW(4), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .l_valid(l_valid), .l_ready(l_ready), .l_reg(l_reg), .l_data(l_data),
    .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData), .pend_mask(pend_mask)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: index 0 = port A, 1 = port L; each entry stamped with an age.
  bit          mv[2];
  logic [3:0]  mreg[2];
  logic [15:0] mdat[2];
  int unsigned mseq[2];
  int          mlast;
  int unsigned edge_cnt = 0;
  logic [15:0] mrf[16];
  logic [15:0] drf[16];

  int          p_g;
  bit          p_ax, p_lx, p_we;
  logic [3:0]  p_ar, p_lr, p_dr;
  logic [15:0] p_ad, p_ld, p_dd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_clear();
    mv[0] = 1'b0; mv[1] = 1'b0;
    mlast = 1;
  endfunction

  function automatic int model_grant();
    if (flush || !rst_n) return -1;
    if (mv[0] && mv[1]) begin
      if (mreg[0] == mreg[1]) return (mseq[1] < mseq[0]) ? 1 : 0;
      return (mlast == 1) ? 0 : 1;
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  task automatic compare_and_plan();
    bit          e_ar, e_lr;
    logic [15:0] e_pm;
    int          g;
    g    = model_grant();
    e_ar = rst_n && !flush && (!mv[0] || g == 0);
    e_lr = rst_n && !flush && (!mv[1] || g == 1);
    e_pm = '0;
    for (int i = 0; i < 2; i++) if (mv[i]) e_pm[mreg[i]] = 1'b1;
    chk("a_ready",   32'(a_ready),   32'(e_ar));
    chk("l_ready",   32'(l_ready),   32'(e_lr));
    chk("WriteReg",  32'(WriteReg),  32'(g >= 0));
    chk("DstReg",    32'(DstReg),    (g >= 0) ? 32'(mreg[g]) : 32'h0);
    chk("DstData",   32'(DstData),   (g >= 0) ? 32'(mdat[g]) : 32'h0);
    chk("pend_mask", 32'(pend_mask), 32'(e_pm));
    p_g  = g;
    p_ax = a_valid && e_ar; p_ar = a_reg; p_ad = a_data;
    p_lx = l_valid && e_lr; p_lr = l_reg; p_ld = l_data;
    p_we = WriteReg; p_dr = DstReg; p_dd = DstData;
  endtask

  task automatic commit();
    if (!rst_n) model_clear();
    else if (flush) begin
      mv[0] = 1'b0; mv[1] = 1'b0;
    end else begin
      if (p_g >= 0) begin
        mv[p_g] = 1'b0;
        mlast = p_g;
        mrf[mreg[p_g]] = mdat[p_g];
      end
      if (p_lx && p_lr != 4'd0) begin
        mv[1] = 1'b1; mreg[1] = p_lr; mdat[1] = p_ld; mseq[1] = 2 * edge_cnt;
      end
      if (p_ax && p_ar != 4'd0) begin
        mv[0] = 1'b1; mreg[0] = p_ar; mdat[0] = p_ad; mseq[0] = 2 * edge_cnt + 1;
      end
      if (p_we) drf[p_dr] = p_dd;
    end
    edge_cnt++;
  endtask

  // Inputs are driven 1 time unit after posedge; the model is checked at negedge.
  task automatic cycle();
    @(negedge clk);
    compare_and_plan();
    @(posedge clk);
    #1;
    commit();
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; l_valid = 1'b0; flush = 1'b0;
    a_reg = 4'd0; l_reg = 4'd0; a_data = 16'h0; l_data = 16'h0;
  endtask

  task automatic rand_inputs(input bit narrow);
    a_valid = ($urandom_range(0, 9) < 7);
    l_valid = ($urandom_range(0, 9) < 7);
    a_reg   = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    l_reg   = narrow ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    a_data  = 16'($urandom);
    l_data  = 16'($urandom);
    flush   = ($urandom_range(0, 19) == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b0);
      cycle();
      chk("rst_we", 32'(WriteReg), 32'h0);
      chk("rst_pm", 32'(pend_mask), 32'h0);
      chk("rst_ar", 32'(a_ready), 32'h0);
      chk("rst_lr", 32'(l_ready), 32'h0);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    chk("rel_ar", 32'(a_ready), 32'h1);
    chk("rel_lr", 32'(l_ready), 32'h1);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      mrf[r] = 16'h0;
      drf[r] = 16'h0;
    end
    idle_inputs();
    model_clear();
    do_reset();

    // single write
    a_valid = 1'b1; a_reg = 4'd5; a_data = 16'h1234;
    cycle();
    idle_inputs(); #1;
    chk("t2_we", 32'(WriteReg), 32'h1);
    chk("t2_reg", 32'(DstReg), 32'h5);
    chk("t2_data", 32'(DstData), 32'h1234);
    chk("t2_pm", 32'(pend_mask), 32'h0020);
    cycle();
    chk("t2_pm_clr", 32'(pend_mask), 32'h0);

    // round-robin after reset (last grant = L)
    do_reset();
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h1111;
    l_valid = 1'b1; l_reg = 4'd2; l_data = 16'h2222;
    cycle();
    idle_inputs(); #1;
    chk("t3_first", 32'(DstData), 32'h1111);
    chk("t3_first_reg", 32'(DstReg), 32'h1);
    cycle();
    chk("t3_second", 32'(DstData), 32'h2222);
    cycle();
    chk("t3_idle", 32'(WriteReg), 32'h0);
    for (int i = 0; i < 10; i++) begin
      a_valid = 1'b1; a_reg = 4'($urandom_range(1, 7));  a_data = 16'($urandom);
      l_valid = 1'b1; l_reg = 4'($urandom_range(8, 15)); l_data = 16'($urandom);
      cycle();
    end
    idle_inputs();
    cycle(); cycle(); cycle();

    // same destination, same edge: L older
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hAAAA;
    l_valid = 1'b1; l_reg = 4'd3; l_data = 16'hBBBB;
    cycle();
    idle_inputs(); #1;
    chk("t4_first", 32'(DstData), 32'hBBBB);
    cycle();
    chk("t4_second", 32'(DstData), 32'hAAAA);
    cycle();
    chk("t4_r3", 32'(drf[3]), 32'hAAAA);
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hAAAA;
    cycle();
    idle_inputs();
    l_valid = 1'b1; l_reg = 4'd3; l_data = 16'hBBBB;
    #1;
    chk("t4b_first", 32'(DstData), 32'hAAAA);
    cycle();
    idle_inputs(); #1;
    chk("t4b_second", 32'(DstData), 32'hBBBB);
    cycle();
    chk("t4b_r3", 32'(drf[3]), 32'hBBBB);

    // register 0 is dropped
    l_valid = 1'b1; l_reg = 4'd0; l_data = 16'hFFFF;
    #1;
    chk("t5_lr", 32'(l_ready), 32'h1);
    cycle();
    idle_inputs(); #1;
    chk("t5_we", 32'(WriteReg), 32'h0);
    chk("t5_pm", 32'(pend_mask), 32'h0);

    // flush with both buffers full
    a_valid = 1'b1; a_reg = 4'd6; a_data = 16'h6666;
    l_valid = 1'b1; l_reg = 4'd7; l_data = 16'h7777;
    cycle();
    flush = 1'b1; #1;
    chk("t6_we", 32'(WriteReg), 32'h0);
    chk("t6_ar", 32'(a_ready), 32'h0);
    chk("t6_lr", 32'(l_ready), 32'h0);
    chk("t6_pm_before", 32'(pend_mask), 32'h00C0);
    cycle();
    idle_inputs(); #1;
    chk("t6_pm", 32'(pend_mask), 32'h0);

    // asynchronous reset mid-cycle
    a_valid = 1'b1; a_reg = 4'd9; a_data = 16'h9999;
    l_valid = 1'b1; l_reg = 4'd10; l_data = 16'hAAAA;
    cycle();
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_we", 32'(WriteReg), 32'h0);
    chk("t6r_reg", 32'(DstReg), 32'h0);
    chk("t6r_pm", 32'(pend_mask), 32'h0);
    model_clear();
    cycle();
    rst_n = 1'b1;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs(i[6]);
      cycle();
    end
    idle_inputs();
    cycle(); cycle(); cycle();
    for (int r = 1; r < 16; r++) chk("regfile", 32'(drf[r]), 32'(mrf[r]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
